// File: rtl/exec_muldiv_ctrl.sv
// Iterative M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow skip the iteration phase and respond on the next cycle.
module exec_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e      state_q;
  logic [4:0]  op_q;
  logic        word_q;
  logic [6:0]  cnt_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] p_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        resp_valid_q;
  logic [63:0] result_q;

  // Request decode
  logic        op_onehot;
  logic        accept;
  logic        req_signed;
  logic        req_is_div;
  logic        req_is_quo;
  logic [63:0] src1_ext;
  logic [63:0] src2_ext;
  logic [63:0] min_val;
  logic        div_zero;
  logic        div_ovf;
  logic [63:0] special_res;
  logic [63:0] special_res_w;
  logic        src1_neg;
  logic        src2_neg;
  logic [63:0] mag1;
  logic [63:0] mag2;

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign busy      = (state_q != S_IDLE);
  assign op_onehot = (req_op != 5'd0) && ((req_op & (req_op - 5'd1)) == 5'd0);
  assign accept    = req_valid && req_ready && op_onehot;

  assign req_signed = req_op[4] | req_op[3] | req_op[1];
  assign req_is_div = |req_op[3:0];
  assign req_is_quo = req_op[3] | req_op[2];

  assign src1_ext = !req_word ? req_src1 :
                    req_signed ? {{32{req_src1[31]}}, req_src1[31:0]} : {32'd0, req_src1[31:0]};
  assign src2_ext = !req_word ? req_src2 :
                    req_signed ? {{32{req_src2[31]}}, req_src2[31:0]} : {32'd0, req_src2[31:0]};

  assign min_val  = req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div_zero = req_is_div && (src2_ext == 64'd0);
  assign div_ovf  = (req_op[3] | req_op[1]) && (src1_ext == min_val) && (src2_ext == '1);

  assign special_res   = div_zero ? (req_is_quo ? '1 : src1_ext)
                                  : (req_is_quo ? src1_ext : 64'd0);
  assign special_res_w = req_word ? {{32{special_res[31]}}, special_res[31:0]} : special_res;

  assign src1_neg = req_signed && src1_ext[63];
  assign src2_neg = req_signed && src2_ext[63];
  assign mag1     = src1_neg ? -src1_ext : src1_ext;
  assign mag2     = src2_neg ? -src2_ext : src2_ext;

  // One iteration step of either datapath, plus the final result if this is the last step
  logic [63:0] mul_p_d;
  logic [64:0] div_sh_d;
  logic        div_ge_d;
  logic [63:0] div_sub_d;
  logic [63:0] div_rem_d;
  logic [63:0] div_quo_d;
  logic [63:0] raw_d;
  logic [63:0] fin_d;

  always_comb begin
    mul_p_d   = b_q[0] ? (p_q + a_q) : p_q;
    div_sh_d  = {p_q, a_q[63]};
    div_ge_d  = (div_sh_d >= {1'b0, b_q});
    div_sub_d = div_sh_d[63:0] - b_q;
    div_rem_d = div_ge_d ? div_sub_d : div_sh_d[63:0];
    div_quo_d = {a_q[62:0], div_ge_d};
    if (op_q[4]) begin
      raw_d = mul_p_d;
    end else if (op_q[3] | op_q[2]) begin
      raw_d = neg_quo_q ? -div_quo_d : div_quo_d;
    end else begin
      raw_d = neg_rem_q ? -div_rem_d : div_rem_d;
    end
    fin_d = word_q ? {{32{raw_d[31]}}, raw_d[31:0]} : raw_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 5'd0;
      word_q       <= 1'b0;
      cnt_q        <= 7'd0;
      a_q          <= 64'd0;
      b_q          <= 64'd0;
      p_q          <= 64'd0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      result_q     <= 64'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            word_q    <= req_word;
            cnt_q     <= req_word ? 7'd32 : 7'd64;
            p_q       <= 64'd0;
            neg_quo_q <= src1_neg ^ src2_neg;
            neg_rem_q <= src1_neg;
            if (req_op[4]) begin
              a_q <= src1_ext;
              b_q <= src2_ext;
            end else begin
              // Left-align W dividends so the quotient bit always comes from a_q[63]
              a_q <= req_word ? {mag1[31:0], 32'd0} : mag1;
              b_q <= mag2;
            end
            if (div_zero || div_ovf) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              result_q     <= special_res_w;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
          end else begin
            cnt_q <= cnt_q - 7'd1;
            if (op_q[4]) begin
              a_q <= {a_q[62:0], 1'b0};
              b_q <= {1'b0, b_q[63:1]};
              p_q <= mul_p_d;
            end else begin
              a_q <= div_quo_d;
              p_q <= div_rem_d;
            end
            if (cnt_q == 7'd1) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              result_q     <= fin_d;
            end
          end
        end
        S_DONE: begin
          if (flush || resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            result_q     <= 64'd0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          result_q     <= 64'd0;
        end
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Randomized self-checking bench for exec_muldiv_ctrl against an arithmetic reference model.
module tb_exec_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic        req_word;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b01000;
  localparam logic [4:0] OP_DIVU = 5'b00100;
  localparam logic [4:0] OP_REM  = 5'b00010;
  localparam logic [4:0] OP_REMU = 5'b00001;

  exec_muldiv_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result and response latency straight from the ISA arithmetic rules
  function automatic void ref_model(input logic [4:0] op, input logic w,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int lat);
    logic is_quo;
    logic sgn;
    is_quo = op[3] | op[2];
    sgn    = op[3] | op[1];
    if (w) begin
      int sa, sb, m32;
      int unsigned ua, ub;
      logic [31:0] r32;
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      m32 = int'(32'h8000_0000);
      lat = 33;
      if (op[4]) r32 = sa * sb;
      else if (sgn) begin
        if (sb == 0) begin r32 = is_quo ? 32'hFFFF_FFFF : sa; lat = 1; end
        else if (sa == m32 && sb == -1) begin r32 = is_quo ? sa : 0; lat = 1; end
        else r32 = is_quo ? sa / sb : sa % sb;
      end else begin
        if (ub == 0) begin r32 = is_quo ? 32'hFFFF_FFFF : ua; lat = 1; end
        else r32 = is_quo ? ua / ub : ua % ub;
      end
      res = {{32{r32[31]}}, r32};
    end else begin
      longint sa, sb, m64;
      longint unsigned ua, ub;
      sa = a; sb = b; ua = a; ub = b;
      m64 = longint'(64'h8000_0000_0000_0000);
      lat = 65;
      if (op[4]) res = a * b;
      else if (sgn) begin
        if (sb == 0) begin res = is_quo ? 64'hFFFF_FFFF_FFFF_FFFF : a; lat = 1; end
        else if (sa == m64 && sb == -1) begin res = is_quo ? a : 64'd0; lat = 1; end
        else res = is_quo ? sa / sb : sa % sb;
      end else begin
        if (ub == 0) begin res = is_quo ? 64'hFFFF_FFFF_FFFF_FFFF : a; lat = 1; end
        else res = is_quo ? ua / ub : ua % ub;
      end
    end
  endfunction

  // Present one request for one cycle; returns #1 after the accepting edge with inputs scrambled
  task automatic start_op(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; req_op = op; req_word = w; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = 5'b1 << $urandom_range(0, 4);
    req_word  = 1'($urandom_range(0, 1));
    req_src1  = {$urandom, $urandom};
    req_src2  = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [4:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
    logic [63:0] exp;
    int explat, lat;
    logic nz_seen;
    ref_model(op, w, a, b, exp, explat);
    check("ready_before", 64'(req_ready), 64'd1);
    start_op(op, w, a, b);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 1;
    nz_seen = 1'b0;
    while (!resp_valid && lat < 100) begin
      if (resp_result !== 64'd0) nz_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("result_zero_when_invalid", 64'(nz_seen), 64'd0);
    check("latency", 64'(lat), 64'(explat));
    check("result", resp_result, exp);
    $display("op=%b w=%0d a=%h b=%h -> %h (exp %h) lat=%0d", op, w, a, b, resp_result, exp, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_result", resp_result, exp);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(resp_valid), 64'd0);
    check("idle_result", resp_result, 64'd0);
  endtask

  initial begin
    logic [4:0]  op;
    logic        w;
    logic [63:0] a, b;
    longint      t;
    int          kind, seen;

    rst = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_word = 1'b0;
    req_src1 = 64'd0; req_src2 = 64'd0; flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_result", resp_result, 64'd0);

    run_op(OP_MUL, 1'b0, 64'd7, -64'sd3, 0);
    run_op(OP_DIV, 1'b0, -64'sd20, 64'd6, 0);
    run_op(OP_REM, 1'b0, -64'sd20, 64'd6, 0);
    run_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_op(OP_REMU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 5);

    // Flush on the 10th CALC cycle drops the operation
    start_op(OP_DIV, 1'b0, 64'd1000, 64'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_busy", 64'(busy), 64'd0);
    check("flush_calc_valid", 64'(resp_valid), 64'd0);
    seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("flush_calc_no_resp", 64'(seen), 64'd0);

    // Flush on the final CALC cycle beats completion
    start_op(OP_MUL, 1'b1, 64'd5, 64'd9);
    repeat (31) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_last_valid", 64'(resp_valid), 64'd0);
    check("flush_last_busy", 64'(busy), 64'd0);

    // Flush in IDLE blocks a simultaneous request
    req_valid = 1'b1; req_op = OP_MUL; req_word = 1'b0; req_src1 = 64'd3; req_src2 = 64'd4;
    flush = 1'b1;
    check("flush_idle_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 64'(busy), 64'd0);

    // Malformed op encodings are ignored
    req_valid = 1'b1; req_op = 5'b00000;
    @(posedge clk); #1;
    check("bad_op_zero", 64'(busy), 64'd0);
    req_op = 5'b00110;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bad_op_two", 64'(busy), 64'd0);

    // Reset while holding a response
    start_op(OP_DIV, 1'b0, 64'd55, 64'd0);
    check("rst_done_pre", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_valid", 64'(resp_valid), 64'd0);
    check("rst_done_busy", 64'(busy), 64'd0);
    check("rst_done_result", resp_result, 64'd0);

    for (int n = 0; n < 40; n++) begin
      op   = 5'b1 << $urandom_range(0, 4);
      w    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (kind == 0) begin
        b = w ? {$urandom, 32'd0} : 64'd0;
      end else if (kind == 1) begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (kind <= 3) begin
        t = longint'($urandom_range(0, 200)) - 64'sd100;
        a = t;
        t = longint'($urandom_range(0, 20)) - 64'sd10;
        b = t;
      end
      run_op(op, w, a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
